// File: rtl/multi_channel_pattern_blinker.sv
// Plays CHANNELS serial bit patterns MSB first on an LED bus, one bit per TICK_RATE clocks,
// with a valid/ready load port, loop/one-shot modes and a shadow set swapped in at pass boundaries.
//
// state | meaning
// IDLE  | LEDs dark; waiting for a load (or launching a load queued at a one-shot end)
// RUN   | playing the active pattern set; loads land in the shadow register
module multi_channel_pattern_blinker #(
    parameter int CHANNELS      = 2,
    parameter int MESSAGE_WIDTH = 32,
    parameter int TICK_RATE     = 100
) (
    input  logic                                 CLK,
    input  logic                                 RESET_N,
    input  logic [CHANNELS*MESSAGE_WIDTH-1:0]    blink_pattern,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic                                 loop_mode,
    input  logic                                 STOP,
    output logic [CHANNELS-1:0]                  LED,
    output logic                                 START,
    output logic                                 DONE,
    output logic                                 busy,
    output logic [$clog2(MESSAGE_WIDTH)-1:0]     blink_index
);

    localparam int PW = CHANNELS * MESSAGE_WIDTH;
    localparam int IW = $clog2(MESSAGE_WIDTH);
    localparam int TW = $clog2(TICK_RATE + 1);
    localparam logic [IW-1:0] IDX_MSB   = IW'(MESSAGE_WIDTH - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_RATE - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       active, active_nxt;
    logic [PW-1:0]       shadow, shadow_nxt;
    logic                active_mode, active_mode_nxt;
    logic                shadow_mode, shadow_mode_nxt;
    logic                pending, pending_nxt;
    logic [TW-1:0]       tick_cnt, tick_nxt;
    logic [IW-1:0]       idx_nxt;
    logic [CHANNELS-1:0] led_nxt;
    logic                start_nxt, done_nxt;
    logic                accept, tick_last;

    function automatic logic [CHANNELS-1:0] bits_at(input logic [PW-1:0] pat,
                                                     input logic [IW-1:0] idx);
        logic [CHANNELS-1:0]      r;
        logic [MESSAGE_WIDTH-1:0] ch;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch   = pat[c*MESSAGE_WIDTH +: MESSAGE_WIDTH];
            r[c] = ch[idx];
        end
        return r;
    endfunction

    assign busy       = (state == S_RUN);
    assign load_ready = !pending;

    always_comb begin
        state_nxt       = state;
        active_nxt      = active;
        shadow_nxt      = shadow;
        active_mode_nxt = active_mode;
        shadow_mode_nxt = shadow_mode;
        pending_nxt     = pending;
        tick_nxt        = tick_cnt;
        idx_nxt         = blink_index;
        led_nxt         = LED;
        start_nxt       = 1'b0;
        done_nxt        = 1'b0;
        accept          = load_valid && !pending && !STOP;
        tick_last       = (tick_cnt == TICK_LAST);

        case (state)
            S_IDLE: begin
                if (STOP) begin
                    pending_nxt = 1'b0;
                end else if (pending || accept) begin
                    // A pending set here was queued on the edge a one-shot pass ended.
                    active_nxt      = pending ? shadow : blink_pattern;
                    active_mode_nxt = pending ? shadow_mode : loop_mode;
                    pending_nxt     = 1'b0;
                    state_nxt       = S_RUN;
                    idx_nxt         = IDX_MSB;
                    tick_nxt        = '0;
                    start_nxt       = 1'b1;
                    led_nxt         = bits_at(active_nxt, IDX_MSB);
                end
            end
            S_RUN: begin
                if (STOP) begin
                    state_nxt   = S_IDLE;
                    led_nxt     = '0;
                    pending_nxt = 1'b0;
                    done_nxt    = 1'b1;
                    idx_nxt     = IDX_MSB;
                    tick_nxt    = '0;
                end else begin
                    if (!tick_last) begin
                        tick_nxt = tick_cnt + TW'(1);
                    end else begin
                        tick_nxt = '0;
                        if (blink_index != '0) begin
                            idx_nxt = blink_index - IW'(1);
                            led_nxt = bits_at(active, idx_nxt);
                        end else if (pending) begin
                            active_nxt      = shadow;
                            active_mode_nxt = shadow_mode;
                            pending_nxt     = 1'b0;
                            idx_nxt         = IDX_MSB;
                            start_nxt       = 1'b1;
                            led_nxt         = bits_at(shadow, IDX_MSB);
                        end else if (active_mode) begin
                            idx_nxt   = IDX_MSB;
                            start_nxt = 1'b1;
                            led_nxt   = bits_at(active, IDX_MSB);
                        end else begin
                            state_nxt = S_IDLE;
                            idx_nxt   = IDX_MSB;
                            led_nxt   = '0;
                            done_nxt  = 1'b1;
                        end
                    end
                    // Accepting on a swap edge is impossible (pending is set), so the
                    // swap above always uses the older shadow contents.
                    if (accept) begin
                        shadow_nxt      = blink_pattern;
                        shadow_mode_nxt = loop_mode;
                        pending_nxt     = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            active      <= '0;
            shadow      <= '0;
            active_mode <= 1'b0;
            shadow_mode <= 1'b0;
            pending     <= 1'b0;
            tick_cnt    <= '0;
            blink_index <= IDX_MSB;
            LED         <= '0;
            START       <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            state       <= state_nxt;
            active      <= active_nxt;
            shadow      <= shadow_nxt;
            active_mode <= active_mode_nxt;
            shadow_mode <= shadow_mode_nxt;
            pending     <= pending_nxt;
            tick_cnt    <= tick_nxt;
            blink_index <= idx_nxt;
            LED         <= led_nxt;
            START       <= start_nxt;
            DONE        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_multi_channel_pattern_blinker.sv
// Self-checking bench for multi_channel_pattern_blinker; a pass-position reference model
// predicts every output each cycle, and each scenario adds its own literal expectations.
module tb_multi_channel_pattern_blinker;

    localparam int CH   = 2;
    localparam int MW   = 8;
    localparam int TR   = 4;
    localparam int PASS = MW * TR;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [CH*MW-1:0] blink_pattern;
    logic            load_valid, loop_mode, STOP;
    logic            load_ready, START, DONE, busy;
    logic [CH-1:0]   LED;
    logic [2:0]      blink_index;
    logic [8:0]      obs;

    int tests = 0;
    int fails = 0;

    // Reference model: pass position in cycles rather than index/tick counters.
    bit         m_run, m_mode, m_shmode, m_pend, m_start, m_done;
    logic [MW-1:0] m_pat [CH];
    logic [MW-1:0] m_sh  [CH];
    int         m_cyc;

    multi_channel_pattern_blinker #(.CHANNELS(CH), .MESSAGE_WIDTH(MW), .TICK_RATE(TR)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .blink_pattern(blink_pattern),
        .load_valid(load_valid), .load_ready(load_ready), .loop_mode(loop_mode),
        .STOP(STOP), .LED(LED), .START(START), .DONE(DONE), .busy(busy),
        .blink_index(blink_index)
    );

    always #5 CLK = ~CLK;
    assign obs = {LED, START, DONE, busy, load_ready, blink_index};

    function automatic logic [8:0] expected();
        logic [CH-1:0] led;
        logic [2:0]    bi;
        logic [MW-1:0] p;
        led = '0;
        bi  = 3'(MW - 1);
        if (m_run) begin
            bi = 3'(MW - 1 - m_cyc / TR);
            for (int c = 0; c < CH; c++) begin
                p      = m_pat[c];
                led[c] = p[bi];
            end
        end
        return {led, m_start, m_done, m_run, !m_pend, bi};
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_shmode = 0; m_pend = 0; m_start = 0; m_done = 0; m_cyc = 0;
        for (int c = 0; c < CH; c++) begin
            m_pat[c] = '0;
            m_sh[c]  = '0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc     = load_valid && !m_pend && !STOP;
        m_start = 0;
        m_done  = 0;
        if (!m_run) begin
            if (STOP) m_pend = 0;
            else if (m_pend) begin
                m_pat = m_sh; m_mode = m_shmode; m_pend = 0;
                m_run = 1; m_cyc = 0; m_start = 1;
            end else if (acc) begin
                for (int c = 0; c < CH; c++) m_pat[c] = blink_pattern[c*MW +: MW];
                m_mode = loop_mode; m_run = 1; m_cyc = 0; m_start = 1;
            end
        end else if (STOP) begin
            m_run = 0; m_pend = 0; m_done = 1;
        end else begin
            if (m_cyc == PASS - 1) begin
                if (m_pend) begin
                    m_pat = m_sh; m_mode = m_shmode; m_pend = 0; m_cyc = 0; m_start = 1;
                end else if (m_mode) begin
                    m_cyc = 0; m_start = 1;
                end else begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_cyc++;
            end
            if (acc) begin
                for (int c = 0; c < CH; c++) m_sh[c] = blink_pattern[c*MW +: MW];
                m_shmode = loop_mode; m_pend = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET_N) model_edge();
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 0; load_valid = 0; loop_mode = 0; STOP = 0; blink_pattern = '0;
        model_reset();
        #12;
        if (obs !== 9'b00_0_0_0_1_111) begin
            fails++; $display("FAIL reset: got %b want %b", obs, 9'b00_0_0_0_1_111);
        end
        tests++;
        RESET_N = 1;
        tick();
    endtask

    task automatic test_one_shot();
        logic [7:0] seq;
        logic [2:0] b;
        seq = 8'b1011_0001;
        blink_pattern = {8'hF0, seq}; loop_mode = 0; load_valid = 1;
        tick();
        load_valid = 0; blink_pattern = 16'($urandom);
        for (int i = 0; i <= PASS; i++) begin
            if (i > 0) tick();
            if (obs !== expected()) begin
                fails++; $display("FAIL one_shot model i=%0d: got %b want %b", i, obs, expected());
            end
            tests++;
            if (i < PASS) begin
                b = 3'(7 - i / TR);
                if (LED !== {(i < 16) ? 1'b1 : 1'b0, seq[b]} || START !== (i == 0) || DONE !== 1'b0) begin
                    fails++; $display("FAIL one_shot seq i=%0d: got LED=%b S=%b D=%b", i, LED, START, DONE);
                end
            end else if (DONE !== 1'b1 || LED !== 2'b00 || load_ready !== 1'b1 || busy !== 1'b0) begin
                fails++; $display("FAIL one_shot end: got D=%b LED=%b rdy=%b busy=%b want 1 00 1 0",
                                  DONE, LED, load_ready, busy);
            end
            tests++;
        end
        tick();
    endtask

    task automatic test_loop();
        blink_pattern = {8'h55, 8'hAA}; loop_mode = 1; load_valid = 1;
        tick();
        load_valid = 0;
        for (int j = 1; j <= 96; j++) begin
            if (j > 1) tick();
            if (obs !== expected()) begin
                fails++; $display("FAIL loop model j=%0d: got %b want %b", j, obs, expected());
            end
            if (START !== (j == 1 || j == 33 || j == 65) || DONE !== 1'b0 || LED[0] !== ~LED[1]) begin
                fails++; $display("FAIL loop strobes j=%0d: got S=%b D=%b LED=%b", j, START, DONE, LED);
            end
            tests += 2;
        end
        STOP = 1;
        tick();
        STOP = 0;
        if (obs !== expected() || DONE !== 1'b1) begin
            fails++; $display("FAIL loop stop: got %b want %b", obs, expected());
        end
        tests++;
    endtask

    task automatic test_shadow();
        blink_pattern = 16'($urandom); loop_mode = 1; load_valid = 1;
        tick();
        load_valid = 0;
        for (int j = 2; j <= 68; j++) begin
            if (j == 6) begin
                blink_pattern = {8'h00, 8'hFF}; loop_mode = 0; load_valid = 1;
            end
            tick();
            if (j == 6) begin
                load_valid = 0; loop_mode = 1; blink_pattern = 16'($urandom);
                if (load_ready !== 1'b0) begin
                    fails++; $display("FAIL shadow ready: got %b want 0", load_ready);
                end
                tests++;
            end
            if (obs !== expected()) begin
                fails++; $display("FAIL shadow model j=%0d: got %b want %b", j, obs, expected());
            end
            tests++;
            if (j >= 33 && j <= 64 && (LED !== 2'b01 || START !== (j == 33))) begin
                fails++; $display("FAIL shadow pass2 j=%0d: got LED=%b S=%b want 01", j, LED, START);
            end
            if (j == 65 && (DONE !== 1'b1 || busy !== 1'b0 || LED !== 2'b00)) begin
                fails++; $display("FAIL shadow done: got D=%b busy=%b LED=%b want 1 0 00", DONE, busy, LED);
            end
            tests++;
        end
    endtask

    task automatic test_stop();
        blink_pattern = 16'($urandom); loop_mode = 1; load_valid = 1;
        tick();
        load_valid = 0;
        for (int j = 2; j <= 11; j++) begin
            if (j == 3) begin
                blink_pattern = {8'h0F, 8'h3C}; loop_mode = 1; load_valid = 1;
            end
            if (j == 11) STOP = 1;
            tick();
            load_valid = 0;
            if (obs !== expected()) begin
                fails++; $display("FAIL stop model j=%0d: got %b want %b", j, obs, expected());
            end
            tests++;
        end
        STOP = 0;
        if (busy !== 1'b0 || LED !== 2'b00 || DONE !== 1'b1 || load_ready !== 1'b1) begin
            fails++; $display("FAIL stop abort: got busy=%b LED=%b D=%b rdy=%b want 0 00 1 1",
                              busy, LED, DONE, load_ready);
        end
        tests++;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (busy !== 1'b0 || LED !== 2'b00 || START !== 1'b0 || DONE !== 1'b0) begin
                fails++; $display("FAIL stop idle j=%0d: got busy=%b LED=%b S=%b D=%b", j, busy, LED, START, DONE);
            end
            tests++;
        end
    endtask

    task automatic test_async_reset();
        blink_pattern = 16'($urandom); loop_mode = 0; load_valid = 1;
        tick();
        load_valid = 0;
        repeat (9) tick();
        #2 RESET_N = 0;
        #1;
        model_reset();
        if (obs !== 9'b00_0_0_0_1_111) begin
            fails++; $display("FAIL async_reset now: got %b want %b", obs, 9'b00_0_0_0_1_111);
        end
        tests++;
        repeat (2) begin
            tick();
            if (obs !== 9'b00_0_0_0_1_111) begin
                fails++; $display("FAIL async_reset hold: got %b want %b", obs, 9'b00_0_0_0_1_111);
            end
            tests++;
        end
        #2 RESET_N = 1;
        tick();
        blink_pattern = 16'($urandom); loop_mode = 0; load_valid = 1;
        for (int i = 0; i <= PASS + 1; i++) begin
            tick();
            load_valid = 0;
            if (obs !== expected() || (i == 0 && START !== 1'b1) || (i == PASS && DONE !== 1'b1)) begin
                fails++; $display("FAIL async_reset replay i=%0d: got %b want %b", i, obs, expected());
            end
            tests++;
        end
    endtask

    task automatic test_stop_load_same();
        blink_pattern = 16'($urandom); loop_mode = 0; load_valid = 1; STOP = 1;
        tick();
        STOP = 0;
        if (START !== 1'b0 || busy !== 1'b0 || obs !== expected()) begin
            fails++; $display("FAIL stop_load ignored: got S=%b busy=%b want 0 0", START, busy);
        end
        tests++;
        tick();
        load_valid = 0;
        if (START !== 1'b1 || busy !== 1'b1 || obs !== expected()) begin
            fails++; $display("FAIL stop_load second: got S=%b busy=%b want 1 1", START, busy);
        end
        tests++;
        for (int i = 1; i <= PASS; i++) begin
            tick();
            if (obs !== expected()) begin
                fails++; $display("FAIL stop_load pass i=%0d: got %b want %b", i, obs, expected());
            end
            tests++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            load_valid    = ($urandom_range(5) == 0);
            loop_mode     = 1'($urandom);
            blink_pattern = 16'($urandom);
            STOP          = ($urandom_range(79) == 0);
            tick();
            if (obs !== expected()) begin
                fails++; $display("FAIL random i=%0d: got %b want %b", i, obs, expected());
            end
            tests++;
        end
        load_valid = 0; STOP = 1;
        tick();
        STOP = 0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_loop();
        test_shadow();
        test_stop();
        test_async_reset();
        test_stop_load_same();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_channel_pattern_blinker.md
Name: multi_channel_pattern_blinker

Overview:
- Parametrised successor to the single-LED tick-rate blinker.
- Plays CHANNELS independent serial bit patterns, MSB first, one bit per TICK_RATE clocks, on a CHANNELS-wide LED bus.
- Adds a valid/ready load handshake, one-shot or loop mode, and a shadow register that swaps in a new pattern set seamlessly at the pass boundary.
- Adds STOP abort and START/DONE strobes.
- Sits between status/debug logic and board LEDs.

Parameters:
CHANNELS, 2, number of independent LED outputs (>=1)
MESSAGE_WIDTH, 32, bits per pattern per channel (>=2)
TICK_RATE, 100, clocks each bit is held (>=1)

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
blink_pattern  input  CHANNELS*MESSAGE_WIDTH  channel c occupies bits [c*MESSAGE_WIDTH +: MESSAGE_WIDTH]
load_valid  input  1  blink_pattern and loop_mode are valid
load_ready  output  1  block can accept a load this cycle
loop_mode  input  1  1 = repeat pass forever, 0 = one pass then idle; sampled with the load
STOP  input  1  abort playback and discard any pending load
LED  output  CHANNELS  current bit of each channel; 0 when idle
START  output  1  one-cycle strobe on the first cycle of every pass
DONE  output  1  one-cycle strobe when a one-shot pass completes or STOP aborts a run
busy  output  1  1 while in RUN
blink_index  output  $clog2(MESSAGE_WIDTH)  bit position being displayed

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State IDLE; all outputs 0 except load_ready=1.
  - blink_index = MESSAGE_WIDTH-1.
  - Active and shadow registers cleared; pending cleared.
  - Reset mid-run takes effect immediately with no DONE strobe.
- Handshake:
  - A load is accepted on a rising edge where load_valid && load_ready.
  - load_ready = !pending. It is 1 in IDLE and 1 in RUN until a shadow load is queued.
  - blink_pattern must be held stable only in the acceptance cycle.
- IDLE, load accepted at edge k:
  - Active register <= pattern; mode <= loop_mode.
  - Enter RUN at k+1.
  - In cycle k+1: blink_index = MESSAGE_WIDTH-1, LED[c] = pattern[c][MSB], START=1, busy=1, tick counter = 0.
- RUN:
  - Tick counter counts 0..TICK_RATE-1.
  - At terminal count, blink_index decrements and the counter returns to 0.
  - Each bit is held exactly TICK_RATE cycles; one pass is MESSAGE_WIDTH*TICK_RATE cycles.
  - LED[c] = active[c][blink_index], registered (no glitches).
- End of pass (terminal count while blink_index==0):
  - pending=1: active <= shadow, mode <= shadow mode, pending <= 0, index <= MSB, START next cycle. Both loop and one-shot runs chain this way.
  - pending=0, loop: index <= MSB, START next cycle; same pattern repeats.
  - pending=0, one-shot: go to IDLE, LED <= 0, DONE=1 for one cycle, busy <= 0.
- Load during RUN:
  - Data goes to the shadow register; pending <= 1; load_ready drops the next cycle.
  - The currently playing pass is not disturbed.
- STOP:
  - In RUN: next cycle is IDLE, LED=0, pending cleared, DONE=1. Any partial pass is abandoned.
  - In IDLE: no effect.
- Simultaneous events:
  - STOP and load_valid in the same cycle: STOP wins and the load is not accepted.
  - Load accepted on the same edge as end of pass: the new data is not visible in that swap. It plays on the following boundary.
- TICK_RATE=1: index changes every cycle. START and DONE never overlap.
- Width rules:
  - blink_index decrements with no underflow; the wrap is explicit to MESSAGE_WIDTH-1.
  - Tick counter width is $clog2(TICK_RATE+1).

Test Plan:
Bench configuration for all scenarios: CHANNELS=2, MESSAGE_WIDTH=8, TICK_RATE=4.
1. Reset, then one-shot load: ch0=8'b1011_0001, ch1=8'hF0, loop_mode=0.
   -> START in cycle k+1.
   -> LED[0] sequence 1,0,1,1,0,0,0,1, each bit held 4 cycles.
   -> LED[1] = 1 for 16 cycles, then 0 for 16 cycles.
   -> DONE exactly 32 cycles after START; LED=0; load_ready=1.
2. Loop load of 8'hAA/8'h55, run 3 passes.
   -> START pulses at cycles 1, 33 and 65 after acceptance.
   -> DONE never asserts.
   -> LED[0] and LED[1] are always complementary.
3. During pass 1 of a loop, load 8'hFF/8'h00 with loop_mode=0.
   -> load_ready low the next cycle.
   -> Pass 1 finishes unchanged.
   -> Pass 2 shows LED[0]=1 and LED[1]=0 for 32 cycles, then DONE and IDLE.
4. STOP asserted at cycle 10 of a loop run with a pending load.
   -> Next cycle: busy=0, LED=0, DONE=1, load_ready=1.
   -> The pending pattern never appears.
5. RESET_N pulsed low mid-bit, asynchronously between edges.
   -> Outputs go to reset values immediately.
   -> No DONE strobe; a subsequent load plays normally.
6. STOP and load_valid in the same IDLE cycle, then load_valid alone.
   -> First load is ignored (no START).
   -> Second load starts the pass normally.
